multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle control FSM for the RV64I processor datapath.
//  - Sequences fetch, decode, execute, memory and writeback over the shared memory port, register file, ALU and PC.
//  - Drives imm_sel to the immediate generator so the correct I/S/B/U/J immediate is valid from DECODE onward.
//  - Counts retired instructions.
// PARAMETERS
//  WORDSIZE  64  datapath word size; width of instret
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         synchronous, active-high
//  opcode        in   7         instruction[6:0] from IR, valid from DECODE onward
//  mem_ready     in   1         memory completes the current access this cycle
//  branch_taken  in   1         ALU compare result, valid in EXEC
//  mem_read      out  1         memory read request
//  mem_write     out  1         memory write request
//  iord          out  1         0 = PC addresses memory, 1 = ALU result addresses memory
//  ir_write      out  1         load IR from memory data
//  pc_write      out  1         unconditional PC update
//  pc_src        out  2         0 = PC+4, 1 = branch/JAL target, 2 = ALU result & ~1 (JALR)
//  reg_write     out  1         register file write enable
//  wb_sel        out  2         0 = ALU, 1 = memory data, 2 = old PC+4, 3 = immediate (LUI)
//  alu_src_a     out  1         0 = rs1, 1 = old PC
//  alu_src_b     out  1         0 = rs2, 1 = immediate
//  alu_op        out  2         0 = add, 1 = compare (branch), 2 = decode by funct3/funct7
//  imm_sel       out  3         0 = I, 1 = S, 2 = B, 3 = U, 4 = J
//  state         out  3         0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP
//  instret       out  WORDSIZE  retired-instruction count
//  trap          out  1         illegal-opcode flag (only with ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  - Reset: state = FETCH, op_q = 0, instret = 0.
//    - All control outputs are 0 during the reset cycle.
//    - FETCH outputs begin the first cycle after reset deasserts.
//    - Reset mid-access abandons that access. No retire is counted.
//  - Outputs are registered-state Moore decodes of {state, op_q}. No output depends combinationally on mem_ready.
//    - Exception: ir_write and pc_write in FETCH assert only in the cycle mem_ready = 1.
//  - FETCH: mem_read = 1, iord = 0. Stay while !mem_ready.
//    - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, then -> DECODE.
//  - DECODE: register op_q <= opcode. imm_sel is driven from opcode in this cycle, from op_q afterwards. -> EXEC.
//  - EXEC, by op_q:
//    - LOAD 0000011 / STORE 0100011: alu_op = add, src_b = imm -> MEM.
//    - OP 0110011: alu_op = 2, src_b = rs2 -> WB.
//    - OP-IMM 0010011: alu_op = 2, src_b = imm -> WB.
//    - LUI 0110111: -> WB.
//    - AUIPC 0010111: src_a = PC, src_b = imm, add -> WB.
//    - BRANCH 1100011: alu_op = 1. pc_write = branch_taken, pc_src = 1. -> FETCH, retire.
//    - JAL 1101111: pc_write, pc_src = 1 -> WB.
//    - JALR 1100111: src_b = imm, add, pc_write, pc_src = 2 -> WB.
//  - MEM: iord = 1, mem_read (LOAD) or mem_write (STORE), held stable until mem_ready.
//    - On mem_ready, LOAD -> WB; STORE -> FETCH and retire.
//  - WB: reg_write = 1 for exactly one cycle; wb_sel per op_q -> FETCH, retire.
//  - Retire: instret += 1 on the transition leaving the final state; wraps at 2^WORDSIZE-1 -> 0.
//  - Latency with zero-wait memory: branch 3, store 4, ALU/LUI/AUIPC/JAL/JALR 4, load 5 cycles. Each wait cycle adds 1.
//  - mem_ready is ignored outside FETCH and MEM.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    - An unlisted opcode in DECODE -> TRAP.
//    - TRAP holds trap = 1 and all enables 0, and is left only by reset. Not retired.
//  ILLEGAL_TRAP_EN undefined:
//    - An unlisted opcode in DECODE -> FETCH as a NOP, retired. State 5 unreachable. trap tied 0.
// TESTING
//  - Reset held 2 cycles, then released with mem_ready = 1 -> state = 0, instret = 0; next cycle mem_read = 1, iord = 0.
//  - R-type 0110011, zero-wait -> FETCH, DECODE, EXEC, WB. reg_write high 1 cycle, wb_sel = 0, instret = 1.
//  - LOAD with mem_ready low 3 MEM cycles -> mem_read, iord stable 4 cycles; WB wb_sel = 1; total 8 cycles.
//  - BRANCH taken = 1 then taken = 0 -> pc_write 1/0 in EXEC, pc_src = 1; each retires in 3 cycles.
//  - Opcode 1111111 -> with ILLEGAL_TRAP_EN: trap = 1 held, instret frozen. Without: back to FETCH, instret +1.
//  - Reset asserted in MEM of a STORE -> mem_write = 0 during the reset cycle, FETCH after release, instret unchanged.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for an RV64I datapath: fetch/decode/exec/mem/wb sequencing and retire count.
// Optional ILLEGAL_TRAP_EN: unlisted opcodes park the FSM in TRAP instead of retiring as a NOP.
module multicycle_control #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                alu_src_a,
    output logic                alu_src_b,
    output logic [1:0]          alu_op,
    output logic [2:0]          imm_sel,
    output logic [2:0]          state,
    output logic [WORDSIZE-1:0] instret,
    output logic                trap
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [2:0]          state_q, next_state;
    logic [6:0]          op_q;
    logic [6:0]          imm_op;
    logic [WORDSIZE-1:0] instret_q;
    logic                retire;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_LUI,
            OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: is_legal = 1'b1;
            default:                              is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:           imm_of = 3'd1;
            OP_BRANCH:          imm_of = 3'd2;
            OP_LUI, OP_AUIPC:   imm_of = 3'd3;
            OP_JAL:             imm_of = 3'd4;
            default:            imm_of = 3'd0;
        endcase
    endfunction

    always_comb begin
        next_state = state_q;
        retire     = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    next_state = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    next_state = S_TRAP;
`else
                    next_state = S_FETCH;
                    retire     = 1'b1;
`endif
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_LOAD, OP_STORE: next_state = S_MEM;
                    OP_BRANCH: begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                    default:           next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        next_state = S_WB;
                    end else begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                end
            end
            S_WB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            instret_q <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == S_DECODE) op_q <= opcode;
            if (retire) instret_q <= instret_q + WORDSIZE'(1);
        end
    end

    // imm_sel must be valid in DECODE itself, before op_q has captured the IR opcode.
    assign imm_op = (state_q == S_DECODE) ? opcode : op_q;

    // Memory handshake: mem_read/mem_write and iord are held constant for the whole
    // access and the access completes on the first cycle mem_ready is high.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'd0;
        imm_sel   = 3'd0;
        trap      = 1'b0;
        if (!reset) begin
            imm_sel = imm_of(imm_op);
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LOAD, OP_STORE: alu_src_b = 1'b1;
                        OP_OP:             alu_op = 2'd2;
                        OP_OPIMM: begin
                            alu_op    = 2'd2;
                            alu_src_b = 1'b1;
                        end
                        OP_AUIPC: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 1'b1;
                        end
                        OP_BRANCH: begin
                            alu_op   = 2'd1;
                            pc_write = branch_taken;
                            pc_src   = 2'd1;
                        end
                        OP_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                        OP_JALR: begin
                            alu_src_b = 1'b1;
                            pc_write  = 1'b1;
                            pc_src    = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = (op_q == OP_LOAD);
                    mem_write = (op_q == OP_STORE);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    case (op_q)
                        OP_LOAD:         wb_sel = 2'd1;
                        OP_JAL, OP_JALR: wb_sel = 2'd2;
                        OP_LUI:          wb_sel = 2'd3;
                        default:         wb_sel = 2'd0;
                    endcase
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:  trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle scripts built from the phase rules,
// replayed against the DUT with every cycle's controls, state and instret compared.
module tb_multicycle_control;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [6:0]   opcode = 7'd0;
    logic         mem_ready = 1'b0;
    logic         branch_taken = 1'b0;
    logic         mem_read, mem_write, iord, ir_write, pc_write, reg_write;
    logic         alu_src_a, alu_src_b, trap;
    logic [1:0]   pc_src, wb_sel, alu_op;
    logic [2:0]   imm_sel, state;
    logic [W-1:0] instret;

    multicycle_control #(.WORDSIZE(W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .state(state),
        .instret(instret), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk;
        bit         rst, mr, tk;
        logic [6:0] op;
        bit         mem_read, mem_write, iord, ir_write, pc_write, reg_write;
        bit         src_a, src_b, trap;
        bit [1:0]   pc_src, wb_sel, alu_op;
        bit [2:0]   imm_sel, state;
        bit [W-1:0] instret;
    } ent_t;

    ent_t exp_q[$];

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit [W-1:0] m_cnt = '0;
    bit [6:0]   m_last_op = 7'd0;
    bit [2:0]   m_pending = 3'd0;

    function automatic bit [2:0] imm_for(input bit [6:0] op);
        case (op)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic ent_t blank(input bit [2:0] st);
        ent_t e;
        e = '{default: '0};
        e.chk     = 1'b1;
        e.mr      = 1'($urandom_range(0, 1));
        e.tk      = 1'($urandom_range(0, 1));
        e.op      = 7'($urandom_range(0, 127));
        e.state   = st;
        e.instret = m_cnt;
        e.imm_sel = imm_for(m_last_op);
        return e;
    endfunction

    function automatic logic [17:0] pack(input ent_t e);
        return {e.mem_read, e.mem_write, e.iord, e.ir_write, e.pc_write, e.pc_src,
                e.reg_write, e.wb_sel, e.src_a, e.src_b, e.alu_op, e.imm_sel, e.trap};
    endfunction

    task automatic plan_reset(input int n, input bit first_unchecked);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e = '{default: '0};
            e.chk     = !(first_unchecked && i == 0);
            e.rst     = 1'b1;
            e.mr      = 1'($urandom_range(0, 1));
            e.op      = 7'($urandom_range(0, 127));
            e.state   = m_pending;
            e.instret = m_cnt;
            exp_q.push_back(e);
            m_pending = 3'd0;
            m_cnt     = '0;
            m_last_op = 7'd0;
        end
    endtask

    // Builds the expected cycle script of one instruction; n returns its cycle count.
    task automatic plan(input bit [6:0] op, input int fw, input int mw, input bit tk,
                        input bit abort_mem, output int n);
        ent_t e;
        bit   is_mem, legal;
        n = 0;
        for (int i = 0; i <= fw; i++) begin
            e = blank(3'd0);
            e.mr = (i == fw);
            e.mem_read = 1'b1;
            e.ir_write = e.mr;
            e.pc_write = e.mr;
            exp_q.push_back(e); n++;
        end
        m_last_op = op;
        e = blank(3'd1);
        e.op = op;
        exp_q.push_back(e); n++;
        legal = op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                           7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};
        if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 3; i++) begin
                e = blank(3'd5);
                e.trap = 1'b1;
                exp_q.push_back(e); n++;
            end
            m_pending = 3'd5;
`else
            m_cnt++;
`endif
            return;
        end
        e = blank(3'd2);
        case (op)
            7'b0000011, 7'b0100011: e.src_b = 1'b1;
            7'b0110011: e.alu_op = 2'd2;
            7'b0010011: begin e.alu_op = 2'd2; e.src_b = 1'b1; end
            7'b0010111: begin e.src_a = 1'b1; e.src_b = 1'b1; end
            7'b1100011: begin e.tk = tk; e.alu_op = 2'd1; e.pc_write = tk; e.pc_src = 2'd1; end
            7'b1101111: begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
            7'b1100111: begin e.src_b = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd2; end
            default: ;
        endcase
        exp_q.push_back(e); n++;
        if (op == 7'b1100011) begin
            m_cnt++;
            return;
        end
        is_mem = (op == 7'b0000011) || (op == 7'b0100011);
        if (is_mem) begin
            if (abort_mem) begin
                m_pending = 3'd3;
                return;
            end
            for (int i = 0; i <= mw; i++) begin
                e = blank(3'd3);
                e.mr = (i == mw);
                e.iord = 1'b1;
                e.mem_read  = (op == 7'b0000011);
                e.mem_write = (op == 7'b0100011);
                exp_q.push_back(e); n++;
            end
            if (op == 7'b0100011) begin
                m_cnt++;
                return;
            end
        end
        e = blank(3'd4);
        e.reg_write = 1'b1;
        case (op)
            7'b0000011:             e.wb_sel = 2'd1;
            7'b1101111, 7'b1100111: e.wb_sel = 2'd2;
            7'b0110111:             e.wb_sel = 2'd3;
            default:                e.wb_sel = 2'd0;
        endcase
        exp_q.push_back(e); n++;
        m_cnt++;
    endtask

    task automatic check_lit(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Replays the queued script: drive on the falling edge, compare 1 ns later.
    task automatic run_q();
        ent_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            reset        = e.rst;
            mem_ready    = e.mr;
            branch_taken = e.tk;
            opcode       = e.op;
            #1;
            cyc++;
            if (e.chk) begin
                tests++;
                if ({pack_dut(), state} !== {pack(e), e.state}) begin
                    fails++;
                    $display("FAIL cycle %0d ctl/state: got %h/%0d, expected %h/%0d",
                             cyc, pack_dut(), state, pack(e), e.state);
                end
                tests++;
                if (instret !== e.instret) begin
                    fails++;
                    $display("FAIL cycle %0d instret: got %0d, expected %0d",
                             cyc, instret, e.instret);
                end
            end
        end
    endtask

    function automatic logic [17:0] pack_dut();
        return {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel, trap};
    endfunction

    initial begin
        int n;
        plan_reset(2, 1'b1);
        run_q();

        plan(7'b0110011, 0, 0, 0, 0, n); check_lit("rtype_cycles", n, 4);
        run_q();
        @(negedge clk); #1;
        check_lit("rtype_instret", instret, 1);
        check_lit("rtype_state_fetch", state, 0);

        plan(7'b0000011, 0, 3, 0, 0, n); check_lit("load_wait_cycles", n, 8);
        plan(7'b1100011, 0, 0, 1, 0, n); check_lit("branch_t_cycles", n, 3);
        plan(7'b1100011, 0, 0, 0, 0, n); check_lit("branch_nt_cycles", n, 3);
        plan(7'b0100011, 1, 0, 0, 0, n); check_lit("store_fwait_cycles", n, 5);
        plan(7'b0010011, 0, 0, 0, 0, n); check_lit("opimm_cycles", n, 4);
        plan(7'b0110111, 0, 0, 0, 0, n); check_lit("lui_cycles", n, 4);
        plan(7'b0010111, 0, 0, 0, 0, n); check_lit("auipc_cycles", n, 4);
        plan(7'b1101111, 0, 0, 0, 0, n); check_lit("jal_cycles", n, 4);
        plan(7'b1100111, 0, 0, 0, 0, n); check_lit("jalr_cycles", n, 4);
        plan(7'b0100011, 0, 0, 0, 0, n); check_lit("store_cycles", n, 4);
        plan(7'b0000011, 0, 0, 0, 0, n); check_lit("load_cycles", n, 5);
        run_q();
        @(negedge clk); #1;
        check_lit("instret_after_mix", instret, 12);

        plan(7'b1111111, 0, 0, 0, 0, n);
`ifdef ILLEGAL_TRAP_EN
        check_lit("illegal_cycles", n, 5);
        run_q();
        check_lit("trap_instret_frozen", instret, 12);
        check_lit("trap_held", trap, 1);
`else
        check_lit("illegal_cycles", n, 2);
        run_q();
        @(negedge clk); #1;
        check_lit("nop_instret", instret, 13);
        check_lit("nop_trap_tied", trap, 0);
`endif

        plan_reset(1, 1'b0);
        plan(7'b0100011, 0, 0, 0, 1, n);
        run_q();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_lit("store_mem_write_before_reset", mem_write, 1);
        check_lit("store_state_mem", state, 3);
        plan_reset(1, 1'b0);
        plan(7'b0110011, 0, 0, 0, 0, n);
        run_q();
        @(negedge clk); #1;
        check_lit("post_abort_instret", instret, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
